// File: rtl/axi_burst_mem_slave.sv
// axi_burst_mem_slave: AXI4 INCR burst responder backed by on-chip RAM.
// One RAM word per 64-byte beat; independent write (AW/W/B) and read (AR/R) engines.
// Optional build macro AXI_MEM_RANGE_CHECK_EN: beats beyond MEM_DEPTH are dropped on
// write and read back as zero, and the bursts that touch them are answered with DECERR.
// Without the macro the word index simply wraps modulo MEM_DEPTH.
module axi_burst_mem_slave #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 512,
    parameter int MEM_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_W / 8;
`ifdef AXI_MEM_RANGE_CHECK_EN
    // full word address plus one carry bit so start + 255 beats never overflows
    localparam int WORD_W = ADDR_W - 5;
`else
    localparam int WORD_W = IDX_W;
`endif

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    w_state_t          w_state_r;
    logic              awready_r, wready_r, bvalid_r;
    logic [1:0]        bresp_r;
    logic [WORD_W-1:0] w_word_r;
    logic [7:0]        w_len_r, w_cnt_r;
    logic              w_err_r, w_dec_r;

    r_state_t          r_state_r;
    logic              arready_r, rvalid_r, rlast_r;
    logic [1:0]        rresp_r;
    logic [DATA_W-1:0] rdata_r;
    logic [WORD_W-1:0] r_word_r;
    logic [7:0]        r_len_r, r_cnt_r;
    logic              r_err_r;

    logic [WORD_W-1:0] aw_word_s, ar_word_s, fetch_word_s;
    logic              w_in_range_s, fetch_in_range_s, fetch_err_s;
    logic [DATA_W-1:0] fetch_data_s;
    logic [1:0]        fetch_resp_s;
    logic              w_fire_s, w_last_beat_s, w_err_next_s, w_dec_next_s;
    logic              r_fire_s, ar_fire_s, aw_fire_s, ar_err_s, aw_err_s;
    logic              unused_s;

`ifdef AXI_MEM_RANGE_CHECK_EN
    assign aw_word_s        = {1'b0, s_axi_awaddr[ADDR_W-1:6]};
    assign ar_word_s        = {1'b0, s_axi_araddr[ADDR_W-1:6]};
    assign w_in_range_s     = (w_word_r < WORD_W'(MEM_DEPTH));
    assign fetch_in_range_s = (fetch_word_s < WORD_W'(MEM_DEPTH));
    assign unused_s         = ^{s_axi_awaddr[5:0], s_axi_araddr[5:0]};
`else
    assign aw_word_s        = s_axi_awaddr[IDX_W+5:6];
    assign ar_word_s        = s_axi_araddr[IDX_W+5:6];
    assign w_in_range_s     = 1'b1;
    assign fetch_in_range_s = 1'b1;
    assign unused_s         = ^{s_axi_awaddr[ADDR_W-1:IDX_W+6], s_axi_awaddr[5:0],
                                s_axi_araddr[ADDR_W-1:IDX_W+6], s_axi_araddr[5:0]};
`endif

    assign aw_fire_s     = s_axi_awvalid & awready_r;
    assign ar_fire_s     = s_axi_arvalid & arready_r;
    assign w_fire_s      = (w_state_r == W_DATA) & wready_r & s_axi_wvalid;
    assign r_fire_s      = rvalid_r & s_axi_rready;
    assign aw_err_s      = (s_axi_awsize != 3'd6) | (s_axi_awburst != 2'b01);
    assign ar_err_s      = (s_axi_arsize != 3'd6) | (s_axi_arburst != 2'b01);
    assign w_last_beat_s = (w_cnt_r == w_len_r);
    // a wlast that disagrees with the beat count only flags the burst; length is always awlen+1
    assign w_err_next_s  = w_err_r | (s_axi_wlast != w_last_beat_s);
    assign w_dec_next_s  = w_dec_r | ~w_in_range_s;

    // Select the word fetched at the next edge: first word on AR accept, else the running index.
    always_comb begin
        fetch_word_s = r_word_r;
        fetch_err_s  = r_err_r;
        if (r_state_r == R_IDLE) begin
            fetch_word_s = ar_word_s;
            fetch_err_s  = ar_err_s;
        end else begin
            fetch_word_s = r_word_r;
            fetch_err_s  = r_err_r;
        end
    end

    // Build the beat payload and response for the fetched word.
    always_comb begin
        fetch_data_s = {DATA_W{1'b0}};
        fetch_resp_s = 2'b00;
        if (!fetch_in_range_s) begin
            fetch_data_s = {DATA_W{1'b0}};
            fetch_resp_s = 2'b11;
        end else begin
            fetch_data_s = mem[fetch_word_s[IDX_W-1:0]];
            fetch_resp_s = fetch_err_s ? 2'b10 : 2'b00;
        end
    end

    // RAM byte-lane write port; no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_fire_s && w_in_range_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_word_r[IDX_W-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Write engine: accept AW, absorb awlen+1 W beats, then hold B until bready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
            w_word_r  <= {WORD_W{1'b0}};
            w_len_r   <= 8'd0;
            w_cnt_r   <= 8'd0;
            w_err_r   <= 1'b0;
            w_dec_r   <= 1'b0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (aw_fire_s) begin
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                        w_word_r  <= aw_word_s;
                        w_len_r   <= s_axi_awlen;
                        w_cnt_r   <= 8'd0;
                        w_err_r   <= aw_err_s;
                        w_dec_r   <= 1'b0;
                        w_state_r <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire_s) begin
                        w_word_r <= w_word_r + WORD_W'(1);
                        w_cnt_r  <= w_cnt_r + 8'd1;
                        w_err_r  <= w_err_next_s;
                        w_dec_r  <= w_dec_next_s;
                        if (w_last_beat_s) begin
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bresp_r   <= w_dec_next_s ? 2'b11 : (w_err_next_s ? 2'b10 : 2'b00);
                            w_state_r <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    awready_r <= 1'b1;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read engine: fetch on AR accept, then prefetch the next word on each non-last R handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rresp_r   <= 2'b00;
            rdata_r   <= {DATA_W{1'b0}};
            r_word_r  <= {WORD_W{1'b0}};
            r_len_r   <= 8'd0;
            r_cnt_r   <= 8'd0;
            r_err_r   <= 1'b0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_fire_s) begin
                        arready_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                        rdata_r   <= fetch_data_s;
                        rresp_r   <= fetch_resp_s;
                        rlast_r   <= (s_axi_arlen == 8'd0);
                        r_word_r  <= ar_word_s + WORD_W'(1);
                        r_len_r   <= s_axi_arlen;
                        r_cnt_r   <= 8'd0;
                        r_err_r   <= ar_err_s;
                        r_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_fire_s) begin
                        if (rlast_r) begin
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                            r_state_r <= R_IDLE;
                        end else begin
                            rdata_r  <= fetch_data_s;
                            rresp_r  <= fetch_resp_s;
                            rlast_r  <= ((r_cnt_r + 8'd1) == r_len_r);
                            r_word_r <= r_word_r + WORD_W'(1);
                            r_cnt_r  <= r_cnt_r + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready_r <= 1'b1;
                    rvalid_r  <= 1'b0;
                    rlast_r   <= 1'b0;
                end
            endcase
        end
    end

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rlast   = rlast_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_rdata   = rdata_r;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Self-checking bench for axi_burst_mem_slave: reference memory model plus
// queues of expected B and R responses filled when bursts are issued.
`timescale 1ns/1ps
module tb_axi_burst_mem_slave;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 512;
    localparam int MEM_DEPTH = 256;
    localparam logic [63:0] ALL_STRB = 64'hFFFF_FFFF_FFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [7:0]        s_axi_awlen = '0, s_axi_arlen = '0;
    logic [2:0]        s_axi_awsize = '0, s_axi_arsize = '0;
    logic [1:0]        s_axi_awburst = '0, s_axi_arburst = '0;
    logic              s_axi_awvalid = 1'b0, s_axi_arvalid = 1'b0;
    logic              s_axi_awready, s_axi_arready;
    logic [DATA_W-1:0] s_axi_wdata = '0;
    logic [63:0]       s_axi_wstrb = '0;
    logic              s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
    logic [1:0]        s_axi_bresp, s_axi_rresp;
    logic              s_axi_bvalid, s_axi_bready = 1'b0;
    logic [DATA_W-1:0] s_axi_rdata;
    logic              s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;

    always #5 clk = ~clk;

    axi_burst_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } rexp_t;

    int                total = 0;
    int                bad   = 0;
    logic [DATA_W-1:0] model [MEM_DEPTH];
    logic [1:0]        bq [$];
    rexp_t             rq [$];

    task automatic check_val(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input longint w, input logic [63:0] strb, input logic [DATA_W-1:0] d,
                               output bit dec);
        int idx;
        dec = 1'b0;
`ifdef AXI_MEM_RANGE_CHECK_EN
        if (w >= MEM_DEPTH) begin
            dec = 1'b1;
            return;
        end
`endif
        idx = int'(w % MEM_DEPTH);
        for (int b = 0; b < 64; b++) begin
            if (strb[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    function automatic logic [DATA_W-1:0] beat_data(input logic [31:0] base, input int i,
                                                   input bit fixed, input logic [DATA_W-1:0] fdata);
        logic [31:0] v;
        v = base + 32'(i);
        return fixed ? fdata : {16{v}};
    endfunction

    task automatic write_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                               input logic [1:0] burst, input int bad_last, input logic [63:0] strb,
                               input logic [31:0] base, input bit fixed, input logic [DATA_W-1:0] fdata);
        bit dec, dec_any, err, hs;
        int n;
        logic [1:0] eb;
        err = (size != 3'd6) || (burst != 2'b01) || (bad_last >= 0);
        dec_any = 1'b0;
        for (int i = 0; i <= len; i++) begin
            model_write(longint'(addr >> 6) + i, strb, beat_data(base, i, fixed, fdata), dec);
            dec_any |= dec;
        end
        bq.push_back(dec_any ? 2'b11 : (err ? 2'b10 : 2'b00));
        s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awsize = size; s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        hs = 1'b0; n = 0;
        while (!hs && n < 50) begin hs = s_axi_awready; tick(); n++; end
        s_axi_awvalid = 1'b0;
        check_val("aw_hs", DATA_W'(hs), DATA_W'(1));
        for (int i = 0; i <= len; i++) begin
            s_axi_wdata  = beat_data(base, i, fixed, fdata);
            s_axi_wstrb  = strb;
            s_axi_wlast  = (bad_last >= 0) ? (i == bad_last) : (i == len);
            s_axi_wvalid = 1'b1;
            hs = 1'b0; n = 0;
            while (!hs && n < 50) begin hs = s_axi_wready; tick(); n++; end
            check_val("w_hs", DATA_W'(hs), DATA_W'(1));
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        check_val("b_latency", DATA_W'(s_axi_bvalid), DATA_W'(1));
        check_val("wready_after_last", DATA_W'(s_axi_wready), DATA_W'(0));
        eb = bq.pop_front();
        check_val("bresp", DATA_W'(s_axi_bresp), DATA_W'(eb));
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check_val("bvalid_clear", DATA_W'(s_axi_bvalid), DATA_W'(0));
        check_val("awready_back", DATA_W'(s_axi_awready), DATA_W'(1));
    endtask

    task automatic read_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                              input logic [1:0] burst, input bit stall);
        rexp_t e;
        bit err, hs, held_v;
        int n, beats, cyc;
        longint w;
        logic [DATA_W-1:0] hd;
        logic hl;
        err = (size != 3'd6) || (burst != 2'b01);
        for (int i = 0; i <= len; i++) begin
            w = longint'(addr >> 6) + i;
            e.last = (i == len);
`ifdef AXI_MEM_RANGE_CHECK_EN
            if (w >= MEM_DEPTH) begin
                e.data = '0; e.resp = 2'b11;
            end else begin
                e.data = model[int'(w)]; e.resp = err ? 2'b10 : 2'b00;
            end
`else
            e.data = model[int'(w % MEM_DEPTH)]; e.resp = err ? 2'b10 : 2'b00;
`endif
            rq.push_back(e);
        end
        s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arsize = size; s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        hs = 1'b0; n = 0;
        while (!hs && n < 50) begin hs = s_axi_arready; tick(); n++; end
        s_axi_arvalid = 1'b0;
        check_val("ar_hs", DATA_W'(hs), DATA_W'(1));
        beats = 0; cyc = 0; held_v = 1'b0; hd = '0; hl = 1'b0;
        while (beats <= len && cyc < 600) begin
            s_axi_rready = stall ? ((cyc % 2) == 0) : 1'b1;
            if (s_axi_rvalid) begin
                if (held_v) begin
                    check_val("r_hold_data", s_axi_rdata, hd);
                    check_val("r_hold_last", DATA_W'(s_axi_rlast), DATA_W'(hl));
                end
                if (s_axi_rready) begin
                    e = rq.pop_front();
                    check_val("rdata", s_axi_rdata, e.data);
                    check_val("rresp", DATA_W'(s_axi_rresp), DATA_W'(e.resp));
                    check_val("rlast", DATA_W'(s_axi_rlast), DATA_W'(e.last));
                    beats++;
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1; hd = s_axi_rdata; hl = s_axi_rlast;
                end
            end
            tick();
            cyc++;
        end
        s_axi_rready = 1'b0;
        check_val("r_beats", DATA_W'(beats), DATA_W'(len + 1));
        if (!stall) check_val("r_tput", DATA_W'(cyc), DATA_W'(len + 1));
        check_val("r_no_extra", DATA_W'(s_axi_rvalid), DATA_W'(0));
        check_val("arready_back", DATA_W'(s_axi_arready), DATA_W'(1));
    endtask

    initial begin
        bit dec;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_awready", DATA_W'(s_axi_awready), DATA_W'(1));
        check_val("rst_arready", DATA_W'(s_axi_arready), DATA_W'(1));
        check_val("rst_wready", DATA_W'(s_axi_wready), DATA_W'(0));
        check_val("rst_bvalid", DATA_W'(s_axi_bvalid), DATA_W'(0));
        check_val("rst_rvalid", DATA_W'(s_axi_rvalid), DATA_W'(0));
        check_val("rst_rlast", DATA_W'(s_axi_rlast), DATA_W'(0));
        check_val("rst_bresp", DATA_W'(s_axi_bresp), DATA_W'(0));
        check_val("rst_rresp", DATA_W'(s_axi_rresp), DATA_W'(0));
        check_val("rst_rdata", s_axi_rdata, '0);
        rst_n = 1'b1;
        tick();

        // 8-beat write then back-to-back and stalled readback
        write_burst(32'h100, 7, 3'd6, 2'b01, -1, ALL_STRB, 32'hA0, 1'b0, '0);
        read_burst(32'h100, 7, 3'd6, 2'b01, 1'b0);
        read_burst(32'h100, 7, 3'd6, 2'b01, 1'b1);

        // partial strobe merge into word 0
        write_burst(32'h0, 0, 3'd6, 2'b01, -1, ALL_STRB, 32'h0, 1'b1, {64{8'hFF}});
        write_burst(32'h0, 0, 3'd6, 2'b01, -1, 64'h0F, 32'h0, 1'b1, {64{8'h11}});
        read_burst(32'h0, 0, 3'd6, 2'b01, 1'b0);

        // protocol errors: early wlast, bad awsize, bad arburst
        write_burst(32'h200, 3, 3'd6, 2'b01, 1, ALL_STRB, 32'hB0, 1'b0, '0);
        write_burst(32'h200, 0, 3'd5, 2'b01, -1, ALL_STRB, 32'hC0, 1'b0, '0);
        read_burst(32'h200, 3, 3'd6, 2'b01, 1'b0);
        read_burst(32'h200, 1, 3'd6, 2'b10, 1'b0);

        // out-of-depth address
`ifdef AXI_MEM_RANGE_CHECK_EN
        write_burst(32'h4000, 0, 3'd6, 2'b01, -1, ALL_STRB, 32'hD0, 1'b0, '0);
`endif
        read_burst(32'h4000, 0, 3'd6, 2'b01, 1'b0);
        read_burst(32'h0, 0, 3'd6, 2'b01, 1'b0);

        // reset in the middle of concurrent 8-beat write and read
        write_burst(32'h800, 7, 3'd6, 2'b01, -1, ALL_STRB, 32'h300, 1'b0, '0);
        s_axi_awaddr = 32'h800; s_axi_awlen = 8'd7; s_axi_awsize = 3'd6; s_axi_awburst = 2'b01;
        s_axi_araddr = 32'h800; s_axi_arlen = 8'd7; s_axi_arsize = 3'd6; s_axi_arburst = 2'b01;
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_axi_wdata = beat_data(32'h400, i, 1'b0, '0);
            s_axi_wstrb = ALL_STRB; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
            check_val("t6_wready", DATA_W'(s_axi_wready), DATA_W'(1));
            check_val("t6_rvalid", DATA_W'(s_axi_rvalid), DATA_W'(1));
            model_write(longint'(32) + i, ALL_STRB, beat_data(32'h400, i, 1'b0, '0), dec);
            tick();
        end
        s_axi_wdata = beat_data(32'h400, 3, 1'b0, '0);
        rst_n = 1'b0;
        #1;
        check_val("t6_rvalid_rst", DATA_W'(s_axi_rvalid), DATA_W'(0));
        check_val("t6_bvalid_rst", DATA_W'(s_axi_bvalid), DATA_W'(0));
        check_val("t6_wready_rst", DATA_W'(s_axi_wready), DATA_W'(0));
        check_val("t6_awready_rst", DATA_W'(s_axi_awready), DATA_W'(1));
        check_val("t6_arready_rst", DATA_W'(s_axi_arready), DATA_W'(1));
        s_axi_wvalid = 1'b0; s_axi_rready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        read_burst(32'h800, 7, 3'd6, 2'b01, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
